// File: rtl/mod_exp_if.sv
// Start/done multiply port between mod_exp (master) and a Montgomery multiplier (slave).
// One transaction: mm_start pulse with operands, then mm_done pulse with mm_result.
interface mod_exp_if #(
   parameter int DATA_W = 1024
);
   logic              mm_start;
   logic [DATA_W-1:0] mm_a;
   logic [DATA_W-1:0] mm_b;
   logic [DATA_W-1:0] mm_m;
   logic [DATA_W-1:0] mm_result;
   logic              mm_done;

   modport master (
      output mm_start, mm_a, mm_b, mm_m,
      input  mm_result, mm_done
   );

   modport slave (
      input  mm_start, mm_a, mm_b, mm_m,
      output mm_result, mm_done
   );
endinterface

// File: rtl/mod_exp.sv
// Left-to-right binary modular exponentiation sequencer: x^e mod M computed as a chain of
// Montgomery multiplications issued to an external multiplier over the mod_exp_if port.
module mod_exp #(
   parameter int DATA_W     = 1024,
   parameter int E_W        = 1024,
   parameter bit CONST_TIME = 1'b1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic [DATA_W-1:0] in_x,
   input  logic [E_W-1:0]    in_e,
   input  logic [DATA_W-1:0] in_m,
   input  logic [DATA_W-1:0] in_r,
   input  logic [DATA_W-1:0] in_r2,
   output logic [DATA_W-1:0] result,
   output logic              done,
   output logic              busy,
   mod_exp_if.master         mm
);
   localparam int IDX_W = (E_W > 1) ? $clog2(E_W) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {OP_TO_MONT, OP_SQ, OP_MUL, OP_FROM_MONT} op_t;

   state_t            state_reg, state_next;
   op_t               op_reg, op_next;
   logic [IDX_W-1:0]  i_reg, i_next;
   logic [E_W-1:0]    e_reg, e_next;
   logic [DATA_W-1:0] m_reg, m_next;
   logic [DATA_W-1:0] acc_reg, acc_next;
   logic [DATA_W-1:0] xt_reg, xt_next;
   logic [DATA_W-1:0] a_reg, a_next;
   logic [DATA_W-1:0] b_reg, b_next;
   logic [DATA_W-1:0] result_reg, result_next;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg  <= S_IDLE;
         op_reg     <= OP_TO_MONT;
         i_reg      <= '0;
         e_reg      <= '0;
         m_reg      <= '0;
         acc_reg    <= '0;
         xt_reg     <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         op_reg     <= op_next;
         i_reg      <= i_next;
         e_reg      <= e_next;
         m_reg      <= m_next;
         acc_reg    <= acc_next;
         xt_reg     <= xt_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         result_reg <= result_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      op_next     = op_reg;
      i_next      = i_reg;
      e_next      = e_reg;
      m_next      = m_reg;
      acc_next    = acc_reg;
      xt_next     = xt_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      result_next = result_reg;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               e_next     = in_e;
               m_next     = in_m;
               acc_next   = in_r;
               xt_next    = '0;
               i_next     = IDX_W'(E_W - 1);
               op_next    = OP_TO_MONT;
               a_next     = in_x;
               b_next     = in_r2;
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: state_next = S_WAIT;
         S_WAIT: begin
            if (mm.mm_done) begin
               state_next = S_ISSUE;
               case (op_reg)
                  OP_TO_MONT: begin
                     xt_next = mm.mm_result;
                     op_next = OP_SQ;
                  end
                  OP_SQ: begin
                     acc_next = mm.mm_result;
                     if (e_reg[i_reg] || CONST_TIME) begin
                        op_next = OP_MUL;
                     end else if (i_reg == '0) begin
                        op_next = OP_FROM_MONT;
                     end else begin
                        i_next  = i_reg - IDX_W'(1);
                        op_next = OP_SQ;
                     end
                  end
                  OP_MUL: begin
                     // Dummy multiply for a zero bit: result is dropped, acc is kept.
                     if (e_reg[i_reg]) acc_next = mm.mm_result;
                     if (i_reg == '0) begin
                        op_next = OP_FROM_MONT;
                     end else begin
                        i_next  = i_reg - IDX_W'(1);
                        op_next = OP_SQ;
                     end
                  end
                  default: begin
                     result_next = mm.mm_result;
                     state_next  = S_DONE;
                  end
               endcase
               if (state_next == S_ISSUE) begin
                  case (op_next)
                     OP_MUL: begin
                        a_next = acc_next;
                        b_next = xt_reg;
                     end
                     OP_FROM_MONT: begin
                        a_next = acc_next;
                        b_next = DATA_W'(1);
                     end
                     default: begin
                        a_next = acc_next;
                        b_next = acc_next;
                     end
                  endcase
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign mm.mm_start = (state_reg == S_ISSUE);
   assign mm.mm_a     = a_reg;
   assign mm.mm_b     = b_reg;
   assign mm.mm_m     = m_reg;
   assign result      = result_reg;
   assign done        = (state_reg == S_DONE);
   assign busy        = (state_reg != S_IDLE);
endmodule

// File: doc/mod_exp.md
# mod_exp

Left-to-right binary modular exponentiation sequencer for the RSA datapath. It computes result = x^e mod M by issuing a sequence of Montgomery multiplications to an external `montgomery` multiplier instance over its start/done port set. This block is the initiator side of that interface: it owns operand selection, operation ordering and conversion into and out of the Montgomery domain. It instantiates no arithmetic itself.

## Interface
- DATA_W, 1024: operand and modulus width.
- E_W, 1024: exponent width. All E_W bits are scanned, MSB first.
- CONST_TIME, 1: when set, a multiply is issued for every exponent bit, and its result is discarded when the bit is 0.
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- in_x  in  DATA_W  base, with in_x < in_m.
- in_e  in  E_W  exponent.
- in_m  in  DATA_W  odd modulus.
- in_r  in  DATA_W  R mod M, where R = 2^DATA_W.
- in_r2  in  DATA_W  R^2 mod M.
- result  out  DATA_W  x^e mod M; holds until the next completion or reset.
- done  out  1  one-cycle pulse when result updates.
- busy  out  1  high from start acceptance through the done cycle.
- mm_start  out  1  one-cycle multiply request.
- mm_a, mm_b, mm_m  out  DATA_W  multiplier operands.
- mm_result  in  DATA_W  equals mm_a·mm_b·R^-1 mod M; valid in the mm_done cycle.
- mm_done  in  1  one-cycle completion pulse from the multiplier.

## Operation
- Reset: result, done, busy, mm_start, mm_a, mm_b and mm_m are all 0. The FSM is in IDLE and all internal registers are 0.
- IDLE: if start=1, latch in_x, in_e, in_m, in_r and in_r2. Load acc := in_r, set i := E_W-1, set busy := 1, then go to ISSUE(TO_MONT).
- Operation sequence. MM(a,b) is one multiplier transaction.
  - TO_MONT: xt := MM(x, r2).
  - For i = E_W-1 down to 0:
    - SQ: acc := MM(acc, acc).
    - MUL, if e[i]=1: acc := MM(acc, xt).
    - MUL, if e[i]=0 and CONST_TIME=1: issue MM(acc, xt) and discard its result.
  - FROM_MONT: acc := MM(acc, 1).
  - DONE.
- ISSUE cycle: assert mm_start=1 and drive mm_a, mm_b and mm_m := latched M, all in the same cycle. Then go to WAIT.
- WAIT:
  - Hold mm_a, mm_b and mm_m stable, with mm_start=0.
  - On mm_done=1, capture mm_result into the destination register.
  - In the same cycle, compute the next operation and go directly to its ISSUE. After FROM_MONT, go to DONE instead.
  - Decrement i after MUL. When CONST_TIME=0 and e[i]=0, decrement i after SQ instead.
- DONE: result := acc, done := 1, busy := 0, then return to IDLE.
- Operation count:
  - CONST_TIME=1: N = E_W + E_W + 2.
  - CONST_TIME=0: N = E_W + popcount(e) + 2.
- Boundary cases:
  - e=0: result = 1 mod M.
  - x=0 with e≠0: result = 0.
  - start while busy is ignored; in_* changes while busy have no effect.
  - mm_done outside WAIT is ignored.
  - resetn=0 at any point, including mid-transaction, returns every output to its reset value in the next cycle. No further mm_start is issued.
- There is no timeout. A multiplier that never asserts mm_done stalls the block in WAIT.

## Timing
- Cycle 0 is the cycle in which start is sampled in IDLE. The first mm_start is in cycle 1.
- L is the multiplier latency: mm_done arrives in cycle c+L when mm_start is in cycle c, with L ≥ 1. Each transaction occupies L+1 cycles.
- done is high in exactly cycle 1 + N·(L+1). result is valid from that cycle onward.
- Back-to-back: start may be accepted in the cycle after done. busy=0 in that cycle.

## Test plan
- Basic: DATA_W=8, E_W=4, CONST_TIME=0, M=13, r=9, r2=3, x=2, e=5, behavioural multiplier with L=3 → result=6. N=8, so done is in cycle 33.
- Constant-time: same stimulus with CONST_TIME=1 → result=6. Exactly 10 mm_start pulses, done in cycle 41.
- Edge exponents: x=12, e=15 → 12. e=0 → 1. x=0, e=5 → 0.
- Handshake: mm_a, mm_b and mm_m are stable from mm_start through mm_done. A spurious mm_done pulse injected in IDLE and in the ISSUE cycle → no state change. start pulsed while busy → ignored, and exactly one done.
- Reset mid-operation: resetn=0 in cycle 15 of the basic case → all outputs 0 on the next edge. A fresh start then yields 6 at the nominal cycle count.
- Full width: DATA_W=1024 with a 1024-bit RSA test vector, checked against a reference model → results match and no mm_start is issued while in WAIT.
